// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: default widths, op codes and
// FSM state encoding.
package shift_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned AMT_W_DEF  = 5;

  // Shift op encodings; 2'b10 is reserved and executes as SLL.
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Decode/EX-side bundle for the shift sequencer.
//   master: decode side (drives start and operands, observes status/result)
//   slave : the sequencer
//   start/op/var_sel/shamt/rs/rt : request and operands
//   busy/stall/done/result       : status and shifted value
interface shift_sequencer_if #(
  parameter int unsigned DATA_W = shift_pkg::DATA_W_DEF,
  parameter int unsigned AMT_W  = shift_pkg::AMT_W_DEF
);

  logic              start;
  logic [1:0]        op;
  logic              var_sel;
  logic [AMT_W-1:0]  shamt;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, op, var_sel, shamt, rs, rt,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, var_sel, shamt, rs, rt,
    output busy, stall, done, result
  );

endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift of data by op.
//   data    : value to shift
//   op      : SLL / SRL / SRA (reserved code shifts left)
//   stepped : data shifted by one position
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] stepped
);

  always_comb begin
    stepped = {data[DATA_W-2:0], 1'b0};
    unique case (op)
      SH_SRL:  stepped = {1'b0, data[DATA_W-1:1]};
      SH_SRA:  stepped = {data[DATA_W-1], data[DATA_W-1:1]};
      default: stepped = {data[DATA_W-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: shifts rt one bit per cycle by an amount
// taken from shamt or rs[4:0], stalling the pipeline while it runs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of shift_sequencer_if
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AMT_W  = AMT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  state_t            state_q, state_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AMT_W-1:0]  amt;
  logic [DATA_W-1:0] stepped;
  logic              stall_c;
  logic              rs_high_unused;

  // Only the low AMT_W bits of rs carry a shift amount.
  assign rs_high_unused = ^bus.rs[DATA_W-1:AMT_W];

  shift_step #(.DATA_W(DATA_W)) u_step (
    .data    (data_q),
    .op      (op_q),
    .stepped (stepped)
  );

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      op_q     <= SH_SLL;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update; result is loaded on entry to DONE so it
  // is visible in the same cycle as the done pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    op_d     = op_q;
    result_d = result_q;
    // Amount is an unsigned 5-bit value; upper bits are implicitly zero.
    amt      = bus.var_sel ? bus.rs[AMT_W-1:0] : bus.shamt;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          data_d = bus.rt;
          op_d   = bus.op;
          if (amt == '0) begin
            state_d  = S_DONE;
            result_d = bus.rt;
          end else begin
            cnt_d   = amt;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = stepped;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d  = S_DONE;
          result_d = stepped;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // Stall must rise in the accepting cycle itself, hence combinational.
  assign stall_c = ((state_q == S_IDLE) && bus.start) || (state_q == S_SHIFT);

  assign bus.stall  = stall_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer against an arithmetic reference.
module tb_shift_sequencer;

  logic clk;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.DATA_W(32), .AMT_W(5)) bus ();

  shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                            input logic [31:0] v);
    case (op)
      2'b01:   return v >> amt;
      2'b11:   return $unsigned($signed(v) >>> amt);
      default: return v << amt;
    endcase
  endfunction

  task automatic scramble();
    bus.op      = 2'($urandom_range(0, 3));
    bus.var_sel = 1'($urandom_range(0, 1));
    bus.shamt   = 5'($urandom);
    bus.rs      = $urandom;
    bus.rt      = $urandom;
  endtask

  // One full operation from an IDLE cycle; leaves the bench at #1 after an
  // edge with the DUT back in IDLE.
  task automatic run_shift(input string name, input logic [1:0] op, input logic vs,
                           input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                           input bit repulse);
    logic [4:0]  amt;
    logic [31:0] exp_res;
    logic [31:0] exp_out;
    logic [2:0]  exp_flags;
    int          last;
    amt     = vs ? rs[4:0] : sh;
    exp_res = ref_shift(op, amt, rt);
    last    = int'(amt) + 1;
    bus.op = op; bus.var_sel = vs; bus.shamt = sh; bus.rs = rs; bus.rt = rt;
    bus.start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s c0 stall/busy/done got %b want 100", name,
               {bus.stall, bus.busy, bus.done});
    end
    @(posedge clk); #1;
    bus.start = repulse;
    scramble();
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      exp_flags = {c < last, c < last, c == last};
      exp_out   = (c == last) ? exp_res : held;
      vectors++;
      if ({bus.stall, bus.busy, bus.done} !== exp_flags) begin
        miscompares++;
        $display("FAIL %s c%0d stall/busy/done got %b want %b", name, c,
                 {bus.stall, bus.busy, bus.done}, exp_flags);
      end
      vectors++;
      if (bus.result !== exp_out) begin
        miscompares++;
        $display("FAIL %s c%0d result got %h want %h", name, c, bus.result, exp_out);
      end
      @(posedge clk); #1;
      if (repulse) scramble();
    end
    bus.start = 1'b0;
    held = exp_res;
    @(negedge clk);
    vectors++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== held) begin
      miscompares++;
      $display("FAIL %s idle flags %b result %h want 000 %h", name,
               {bus.stall, bus.busy, bus.done}, bus.result, held);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    scramble();
    held = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset flags %b result %h want 000 0",
               {bus.stall, bus.busy, bus.done}, bus.result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_shift("sll4",      2'b00, 1'b0, 5'd4,  32'h0,        32'h0000_0001, 1'b0);
    run_shift("srav3",     2'b11, 1'b1, 5'd17, 32'h0000_0FE3, 32'h8000_0000, 1'b0);
    run_shift("srlv3",     2'b01, 1'b1, 5'd9,  32'h0000_0FE3, 32'h8000_0000, 1'b0);
    run_shift("amt0",      2'b00, 1'b0, 5'd0,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0);
    run_shift("sll31",     2'b00, 1'b0, 5'd31, 32'h0,        32'hFFFF_FFFF, 1'b0);
    run_shift("sra31",     2'b11, 1'b0, 5'd31, 32'h0,        32'h8000_0000, 1'b0);
    run_shift("reserved",  2'b10, 1'b0, 5'd5,  32'h0,        32'h1234_5679, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_shift("repulse6",  2'b01, 1'b0, 5'd6,  32'h0,        32'hF00D_CAFE, 1'b1);
    run_shift("repulse0",  2'b11, 1'b1, 5'd3,  32'h0000_0020, 32'h9000_0001, 1'b1);
  endtask

  // Start held high straight through: DONE must not accept, the following
  // IDLE cycle must.
  task automatic test_back_to_back();
    logic [2:0]  exp_flags [7];
    logic [31:0] a_res;
    logic [31:0] b_res;
    logic [31:0] exp_out;
    exp_flags = '{3'b100, 3'b110, 3'b110, 3'b001, 3'b100, 3'b110, 3'b001};
    a_res = ref_shift(2'b00, 5'd2, 32'h0000_0003);
    b_res = ref_shift(2'b01, 5'd1, 32'h0000_0100);
    bus.op = 2'b00; bus.var_sel = 1'b0; bus.shamt = 5'd2; bus.rt = 32'h0000_0003;
    bus.start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_out = (c < 3) ? held : ((c < 6) ? a_res : b_res);
      vectors++;
      if ({bus.stall, bus.busy, bus.done} !== exp_flags[c] || bus.result !== exp_out) begin
        miscompares++;
        $display("FAIL b2b c%0d flags %b result %h want %b %h", c,
                 {bus.stall, bus.busy, bus.done}, bus.result, exp_flags[c], exp_out);
      end
      @(posedge clk); #1;
      if (c == 0) begin
        bus.op = 2'b01; bus.var_sel = 1'b1; bus.rs = 32'hFFFF_FFE1; bus.rt = 32'h0000_0100;
      end
      if (c == 4) bus.start = 1'b0;
    end
    held = b_res;
  endtask

  task automatic test_reset_mid();
    bus.op = 2'b00; bus.var_sel = 1'b0; bus.shamt = 5'd10; bus.rt = 32'h0000_0F0F;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid flags %b result %h want 000 0",
               {bus.stall, bus.busy, bus.done}, bus.result);
    end
    held = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold c%0d done %b busy %b want 0 0", c, bus.done, bus.busy);
      end
    end
    @(posedge clk); #1;
    run_shift("post_reset", 2'b00, 1'b0, 5'd1, 32'h0, 32'h0000_0002, 1'b0);
    vectors++;
    if (held !== 32'h0000_0004) begin
      miscompares++;
      $display("FAIL post_reset model got %h want 00000004", held);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_shift("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom),
                $urandom, $urandom, bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the CPU's shift path (SLL/SRL/SRA/SLLV/SRLV/SRAV).
- Selects the shift amount from one of two sources:
  - the instruction shamt field, zero-extended from 5 to 32 bits;
  - rs[4:0] for the variable forms.
- Shifts rt one bit per cycle and presents the result to the EX-stage result mux.
- Holds the pipeline with a stall request while the shift runs.

Parameters:
- DATA_W, 32, shift operand and result width.
- AMT_W, 5, shift-amount width; the amount is zero-extended, never sign-extended.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from decode; sampled only in IDLE.
- op  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SLL).
- var_sel  in  1  0: amount = shamt; 1: amount = rs[4:0].
- shamt  in  5  instr[10:6].
- rs  in  DATA_W  rs operand; only bits [4:0] are used.
- rt  in  DATA_W  value to shift.
- busy  out  1  registered; high while in SHIFT.
- stall  out  1  combinational: (IDLE && start) || SHIFT.
- done  out  1  one-cycle pulse; result is valid.
- result  out  DATA_W  shifted value; held until the next accepted start.

Behaviour:
- States: IDLE, SHIFT, DONE. The state machine is a registered state plus a 5-bit down-counter cnt.
- Reset (asynchronous, whenever rst_n=0, including mid-operation):
  - state=IDLE, cnt=0, working register=0.
  - result=0, busy=0, done=0.
  - Any in-flight shift is abandoned with no done pulse.
- IDLE with start=1 (the accepting edge):
  - Latch data=rt and op.
  - Latch amt = var_sel ? rs[4:0] : shamt, zero-extended.
  - amt==0: go to DONE.
  - Otherwise: cnt=amt, go to SHIFT.
- SHIFT, each cycle:
  - SLL: data<<1, zero fill.
  - SRL: data>>1, zero fill.
  - SRA: data>>1, filled with data[DATA_W-1].
  - cnt decrements by 1. When cnt==1 before the decrement, go to DONE.
- DONE:
  - result=data, done=1 for exactly this cycle, stall=0 so the pipeline captures result.
  - Unconditionally go to IDLE next cycle.
- Latency: start accepted in cycle 0 means done in cycle amt+1.
  - amt=0 gives done in cycle 1.
  - amt=31 gives done in cycle 32.
  - No shift runs longer than 32 cycles.
- start outside IDLE (SHIFT or DONE) is ignored; no queueing.
  - Decode must hold start until stall drops.
  - Back-to-back shifts therefore leave one idle gap: DONE, then IDLE, then accept.
- op, var_sel, shamt, rs and rt are sampled only at the accepting edge. Later changes do not affect an operation in flight.
- Reserved op 10 behaves exactly as SLL; no error is flagged.
- result changes only in DONE and on reset.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11;
  - state encodings S_IDLE, S_SHIFT, S_DONE;
  - DATA_W/AMT_W defaults.
- One natural sub-module, shift_step: a combinational single-bit shift of data by op, instantiated once in the datapath.
- Amount zero-extension is done inline.

Test Plan:
- SLL, var_sel=0, shamt=4, rt=0x00000001: stall high in cycle 0, busy cycles 1–4, done in cycle 5, result=0x00000010.
- SRAV, var_sel=1, rs=0x00000FE3 (amt=3), rt=0x80000000: result=0xF0000000, done in cycle 4. Same with SRLV gives 0x10000000.
- shamt=0, rt=0xDEADBEEF: no SHIFT state, done in cycle 1, result=0xDEADBEEF.
- SLL shamt=31, rt=0xFFFFFFFF: done in cycle 32, result=0x80000000. SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
- start re-pulsed with different operands during SHIFT and DONE: ignored, original result delivered. The next start is accepted only in IDLE.
- rst_n low in cycle 3 of a 10-cycle shift: outputs go to 0 immediately with no done pulse. After release, a new SLL shamt=1, rt=0x2 gives 0x4 in cycle 2.
